hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter CNT_WD, default 32: width of each performance counter.
REQ-002 Parameter MEM_TIMEOUT, default 255: number of MEM_WAIT cycles after which mem_timeout is set; legal range 1..255.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 reset  in  1  asynchronous, active-high.
REQ-005 d_to_h_bus  in  11  {need_use_rs[10], rs1_addr[9:5], rs2_addr[4:0]} for the instruction in decode.
REQ-006 decode_valid  in  1  decode stage holds a valid instruction.
REQ-007 bj_taken  in  1  decode resolved a taken branch or jump; the decode stage has already qualified it with valid.
REQ-008 e_valid, e_rf_we, e_is_load  in  1 each  execute-stage valid, register write enable, and load flag.
REQ-009 e_rf_dest  in  5  execute-stage destination register.
REQ-010 e_rs1_addr, e_rs2_addr  in  5 each  execute-stage source registers.
REQ-011 m_valid, m_rf_we, m_is_load, m_mem_access  in  1 each  memory-stage valid, write enable, load flag, and data-memory access flag.
REQ-012 m_rf_dest  in  5  memory-stage destination register.
REQ-013 w_rf_we  in  1, w_rf_dest  in  5  writeback-stage write enable and destination.
REQ-014 dmem_ready  in  1  data memory has completed the current access this cycle.
REQ-015 perf_clr  in  1  synchronous clear of both performance counters.
REQ-016 stall_fetch, stall_decode, stall_execute, stall_memory  out  1 each  hold the corresponding pipeline register.
REQ-017 flush_decode, flush_execute  out  1 each  clear the corresponding pipeline register.
REQ-018 forward_rs1_select_d, forward_rs2_select_d  out  2 each  decode-side operand select.
REQ-019 forward_rs1_select_e, forward_rs2_select_e  out  2 each  execute-side operand select.
REQ-020 stall_cnt, flush_cnt  out  CNT_WD each  performance counters.
REQ-021 mem_timeout  out  1  sticky memory-timeout flag.

Function
REQ-022 Hit definition: a stage hits source register X when X≠0, the stage's write enable is 1, the stage's destination equals X, and, for the execute and memory stages, the stage's valid is 1.
REQ-023 load_use is 1 when decode_valid is 1 and execute hits rs1 or rs2 with e_is_load=1.
REQ-024 br_dep is 1 when decode_valid and need_use_rs are both 1 and either condition holds:
- execute hits rs1 or rs2;
- memory hits rs1 or rs2 with m_is_load=1.
REQ-025 hz is defined as load_use OR br_dep.
REQ-026 mem_busy is defined as m_valid AND m_mem_access AND NOT dmem_ready.
REQ-027 stall_fetch and stall_decode SHALL both equal hz OR mem_busy.
REQ-028 stall_execute and stall_memory SHALL both equal mem_busy.
REQ-029 flush_execute SHALL equal hz AND NOT mem_busy; this inserts one bubble per hazard cycle.
REQ-030 flush_decode SHALL equal bj_taken AND NOT hz AND NOT mem_busy; flush is never asserted while decode is stalled.
REQ-031 Decode select per source register, in priority order:
- memory hit with m_is_load=0 gives 2'b10;
- memory hit with m_is_load=1 gives 2'b00, and no writeback fallback is applied;
- otherwise a writeback hit gives 2'b01;
- otherwise 2'b00.
REQ-032 Execute select uses the same rule as REQ-031 applied to e_rs1_addr/e_rs2_addr; a memory-stage load hit yields 2'b00, because load_use already prevents that case.
REQ-033 Every output other than the counters and mem_timeout is purely combinational, with zero latency.
REQ-034 The FSM has two states, RUN and MEM_WAIT:
- RUN goes to MEM_WAIT when mem_busy=1;
- MEM_WAIT goes to RUN when dmem_ready=1 or m_valid=0;
- it stays in the current state otherwise.
REQ-035 wait_cnt (8 bits) SHALL increment each cycle in MEM_WAIT, saturate at MEM_TIMEOUT, and clear to 0 in RUN.
REQ-036 mem_timeout SHALL be set on the edge where wait_cnt reaches MEM_TIMEOUT, and cleared only by reset.
REQ-037 stall_cnt SHALL increment on each cycle with stall_decode=1, saturating at all-ones.
REQ-038 flush_cnt SHALL increment on each cycle with flush_decode=1, saturating at all-ones.
REQ-039 perf_clr SHALL zero both counters and has priority over increment in the same cycle.

Reset
REQ-040 Reset forces state=RUN, wait_cnt=0, stall_cnt=0, flush_cnt=0, and mem_timeout=0, immediately and independent of clk.
REQ-041 Reset asserted mid-MEM_WAIT SHALL abort the wait; after release the block resumes in RUN with the counters at zero.

Verification
REQ-042 Load-use: e_valid=1, e_is_load=1, e_rf_dest=5, decode rs1=5 -> stall_fetch=stall_decode=flush_execute=1 for one cycle, stall_cnt increments by 1, stall_execute=0.
REQ-043 Branch on ALU result: need_use_rs=1, rs2=7, execute hits 7 with e_is_load=0, bj_taken=1 -> stall_decode=1 and flush_decode=0; next cycle, with x7 now in memory -> forward_rs2_select_d=2'b10 and flush_decode=1.
REQ-044 Forward priority: memory and writeback both write x3, decode rs1=3, m_is_load=0 -> forward_rs1_select_d=2'b10; with m_is_load=1 and need_use_rs=0 -> 2'b00; rs1=0 -> 2'b00.
REQ-045 Memory wait: m_valid=m_mem_access=1, dmem_ready=0 for 4 cycles then 1 -> all four stalls=1 during the wait, flush_* =0, FSM returns to RUN, mem_timeout stays 0.
REQ-046 Timeout: dmem_ready held 0 with MEM_TIMEOUT=3 -> mem_timeout=1 after the third MEM_WAIT cycle; it stays 1 after dmem_ready=1 and clears only on reset.
REQ-047 Counter edge: stall_cnt preloaded to all-ones (CNT_WD=4) plus a stall -> stays 4'hF; perf_clr together with a stall -> both counters 0.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stall/flush generation, operand forwarding selects,
// memory-wait watchdog and saturating stall/flush performance counters.
module hazard_ctrl #(
    parameter int CNT_WD      = 32,
    parameter int MEM_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [10:0]       d_to_h_bus,
    input  logic              decode_valid,
    input  logic              bj_taken,
    input  logic              e_valid,
    input  logic              e_rf_we,
    input  logic              e_is_load,
    input  logic [4:0]        e_rf_dest,
    input  logic [4:0]        e_rs1_addr,
    input  logic [4:0]        e_rs2_addr,
    input  logic              m_valid,
    input  logic              m_rf_we,
    input  logic              m_is_load,
    input  logic              m_mem_access,
    input  logic [4:0]        m_rf_dest,
    input  logic              w_rf_we,
    input  logic [4:0]        w_rf_dest,
    input  logic              dmem_ready,
    input  logic              perf_clr,
    output logic              stall_fetch,
    output logic              stall_decode,
    output logic              stall_execute,
    output logic              stall_memory,
    output logic              flush_decode,
    output logic              flush_execute,
    output logic [1:0]        forward_rs1_select_d,
    output logic [1:0]        forward_rs2_select_d,
    output logic [1:0]        forward_rs1_select_e,
    output logic [1:0]        forward_rs2_select_e,
    output logic [CNT_WD-1:0] stall_cnt,
    output logic [CNT_WD-1:0] flush_cnt,
    output logic              mem_timeout
);

    typedef enum logic {RUN, MEM_WAIT} state_t;

    localparam logic [7:0]        TO_LIM  = 8'(MEM_TIMEOUT);
    localparam logic [CNT_WD-1:0] CNT_ONE = 1;

    function automatic logic src_hit(input logic [4:0] src, input logic vld,
                                     input logic we, input logic [4:0] dest);
        return (src != 5'd0) && vld && we && (dest == src);
    endfunction

    // A load still in memory has no data yet, so it must not fall back to writeback.
    function automatic logic [1:0] fwd_sel(input logic m_hit, input logic m_load,
                                           input logic w_hit);
        if (m_hit)
            return m_load ? 2'b00 : 2'b10;
        else if (w_hit)
            return 2'b01;
        else
            return 2'b00;
    endfunction

    function automatic logic [CNT_WD-1:0] sat_inc(input logic [CNT_WD-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    logic       need_use_rs;
    logic [4:0] rs1_addr, rs2_addr;
    logic       e_hit1, e_hit2, m_hit1, m_hit2, w_hit1, w_hit2;
    logic       me_hit1, me_hit2, we_hit1, we_hit2;
    logic       load_use, br_dep, hz, mem_busy;

    assign need_use_rs = d_to_h_bus[10];
    assign rs1_addr    = d_to_h_bus[9:5];
    assign rs2_addr    = d_to_h_bus[4:0];

    assign e_hit1  = src_hit(rs1_addr, e_valid, e_rf_we, e_rf_dest);
    assign e_hit2  = src_hit(rs2_addr, e_valid, e_rf_we, e_rf_dest);
    assign m_hit1  = src_hit(rs1_addr, m_valid, m_rf_we, m_rf_dest);
    assign m_hit2  = src_hit(rs2_addr, m_valid, m_rf_we, m_rf_dest);
    assign w_hit1  = src_hit(rs1_addr, 1'b1, w_rf_we, w_rf_dest);
    assign w_hit2  = src_hit(rs2_addr, 1'b1, w_rf_we, w_rf_dest);
    assign me_hit1 = src_hit(e_rs1_addr, m_valid, m_rf_we, m_rf_dest);
    assign me_hit2 = src_hit(e_rs2_addr, m_valid, m_rf_we, m_rf_dest);
    assign we_hit1 = src_hit(e_rs1_addr, 1'b1, w_rf_we, w_rf_dest);
    assign we_hit2 = src_hit(e_rs2_addr, 1'b1, w_rf_we, w_rf_dest);

    assign load_use = decode_valid && e_is_load && (e_hit1 || e_hit2);
    // Branches resolve in decode, so they also wait on ALU results still in execute.
    assign br_dep   = decode_valid && need_use_rs &&
                      (e_hit1 || e_hit2 || (m_is_load && (m_hit1 || m_hit2)));
    assign hz       = load_use || br_dep;
    assign mem_busy = m_valid && m_mem_access && !dmem_ready;

    assign stall_fetch   = hz || mem_busy;
    assign stall_decode  = hz || mem_busy;
    assign stall_execute = mem_busy;
    assign stall_memory  = mem_busy;
    assign flush_execute = hz && !mem_busy;
    assign flush_decode  = bj_taken && !hz && !mem_busy;

    assign forward_rs1_select_d = fwd_sel(m_hit1, m_is_load, w_hit1);
    assign forward_rs2_select_d = fwd_sel(m_hit2, m_is_load, w_hit2);
    assign forward_rs1_select_e = fwd_sel(me_hit1, m_is_load, we_hit1);
    assign forward_rs2_select_e = fwd_sel(me_hit2, m_is_load, we_hit2);

    state_t     state_q;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       mem_timeout_q;

    assign wait_cnt_d = (wait_cnt_q == TO_LIM) ? wait_cnt_q : wait_cnt_q + 8'd1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= RUN;
            wait_cnt_q    <= 8'd0;
            mem_timeout_q <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    wait_cnt_q <= 8'd0;
                    if (mem_busy)
                        state_q <= MEM_WAIT;
                end
                MEM_WAIT: begin
                    wait_cnt_q <= wait_cnt_d;
                    if (wait_cnt_d == TO_LIM)
                        mem_timeout_q <= 1'b1;
                    if (dmem_ready || !m_valid)
                        state_q <= RUN;
                end
                default: state_q <= RUN;
            endcase
        end
    end

    assign mem_timeout = mem_timeout_q;

    logic [CNT_WD-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_WD-1:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (perf_clr) begin
            stall_cnt_d = '0;
            flush_cnt_d = '0;
        end else begin
            if (stall_decode)
                stall_cnt_d = sat_inc(stall_cnt_q);
            if (flush_decode)
                flush_cnt_d = sat_inc(flush_cnt_q);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: two instances share stimulus, one with a
// short memory timeout so the watchdog can be exercised quickly.
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] d_to_h_bus;
    logic        decode_valid, bj_taken;
    logic        e_valid, e_rf_we, e_is_load;
    logic [4:0]  e_rf_dest, e_rs1_addr, e_rs2_addr;
    logic        m_valid, m_rf_we, m_is_load, m_mem_access;
    logic [4:0]  m_rf_dest;
    logic        w_rf_we;
    logic [4:0]  w_rf_dest;
    logic        dmem_ready, perf_clr;

    logic        stall_fetch, stall_decode, stall_execute, stall_memory;
    logic        flush_decode, flush_execute;
    logic [1:0]  fs1_d, fs2_d, fs1_e, fs2_e;
    logic [3:0]  stall_cnt, flush_cnt;
    logic        mem_timeout;

    logic        b_stall_fetch, b_stall_decode, b_stall_execute, b_stall_memory;
    logic        b_flush_decode, b_flush_execute;
    logic [1:0]  b_fs1_d, b_fs2_d, b_fs1_e, b_fs2_e;
    logic [3:0]  b_stall_cnt, b_flush_cnt;
    logic        b_mem_timeout;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.CNT_WD(4), .MEM_TIMEOUT(255)) u_a (
        .clk(clk), .reset(reset), .d_to_h_bus(d_to_h_bus), .decode_valid(decode_valid),
        .bj_taken(bj_taken), .e_valid(e_valid), .e_rf_we(e_rf_we), .e_is_load(e_is_load),
        .e_rf_dest(e_rf_dest), .e_rs1_addr(e_rs1_addr), .e_rs2_addr(e_rs2_addr),
        .m_valid(m_valid), .m_rf_we(m_rf_we), .m_is_load(m_is_load),
        .m_mem_access(m_mem_access), .m_rf_dest(m_rf_dest), .w_rf_we(w_rf_we),
        .w_rf_dest(w_rf_dest), .dmem_ready(dmem_ready), .perf_clr(perf_clr),
        .stall_fetch(stall_fetch), .stall_decode(stall_decode),
        .stall_execute(stall_execute), .stall_memory(stall_memory),
        .flush_decode(flush_decode), .flush_execute(flush_execute),
        .forward_rs1_select_d(fs1_d), .forward_rs2_select_d(fs2_d),
        .forward_rs1_select_e(fs1_e), .forward_rs2_select_e(fs2_e),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt), .mem_timeout(mem_timeout)
    );

    hazard_ctrl #(.CNT_WD(4), .MEM_TIMEOUT(3)) u_b (
        .clk(clk), .reset(reset), .d_to_h_bus(d_to_h_bus), .decode_valid(decode_valid),
        .bj_taken(bj_taken), .e_valid(e_valid), .e_rf_we(e_rf_we), .e_is_load(e_is_load),
        .e_rf_dest(e_rf_dest), .e_rs1_addr(e_rs1_addr), .e_rs2_addr(e_rs2_addr),
        .m_valid(m_valid), .m_rf_we(m_rf_we), .m_is_load(m_is_load),
        .m_mem_access(m_mem_access), .m_rf_dest(m_rf_dest), .w_rf_we(w_rf_we),
        .w_rf_dest(w_rf_dest), .dmem_ready(dmem_ready), .perf_clr(perf_clr),
        .stall_fetch(b_stall_fetch), .stall_decode(b_stall_decode),
        .stall_execute(b_stall_execute), .stall_memory(b_stall_memory),
        .flush_decode(b_flush_decode), .flush_execute(b_flush_execute),
        .forward_rs1_select_d(b_fs1_d), .forward_rs2_select_d(b_fs2_d),
        .forward_rs1_select_e(b_fs1_e), .forward_rs2_select_e(b_fs2_e),
        .stall_cnt(b_stall_cnt), .flush_cnt(b_flush_cnt), .mem_timeout(b_mem_timeout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic idle();
        d_to_h_bus = '0; decode_valid = 0; bj_taken = 0;
        e_valid = 0; e_rf_we = 0; e_is_load = 0; e_rf_dest = '0;
        e_rs1_addr = '0; e_rs2_addr = '0;
        m_valid = 0; m_rf_we = 0; m_is_load = 0; m_mem_access = 0; m_rf_dest = '0;
        w_rf_we = 0; w_rf_dest = '0; dmem_ready = 0; perf_clr = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #1;
        reset = 1'b0;
        #1;
    endtask

    task automatic set_load_use();
        decode_valid = 1; d_to_h_bus = {1'b0, 5'd5, 5'd0};
        e_valid = 1; e_rf_we = 1; e_is_load = 1; e_rf_dest = 5'd5;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        #3;
        chk("rst_stall_cnt", stall_cnt, 4'h0);
        chk("rst_flush_cnt", flush_cnt, 4'h0);
        chk("rst_timeout", mem_timeout, 1'b0);
        chk("rst_stall_fetch", stall_fetch, 1'b0);
        @(negedge clk);
        reset = 1'b0;
        tick();

        // Load-use hazard
        set_load_use();
        #1;
        chk("lu_stall_fetch", stall_fetch, 1'b1);
        chk("lu_stall_decode", stall_decode, 1'b1);
        chk("lu_flush_execute", flush_execute, 1'b1);
        chk("lu_stall_execute", stall_execute, 1'b0);
        chk("lu_stall_memory", stall_memory, 1'b0);
        tick();
        idle();
        #1;
        chk("lu_stall_cnt", stall_cnt, 4'h1);
        chk("lu_stall_cleared", stall_decode, 1'b0);

        // Branch depending on an ALU result in execute, then forwarded from memory
        decode_valid = 1; d_to_h_bus = {1'b1, 5'd0, 5'd7}; bj_taken = 1;
        e_valid = 1; e_rf_we = 1; e_is_load = 0; e_rf_dest = 5'd7;
        #1;
        chk("br_stall_decode", stall_decode, 1'b1);
        chk("br_flush_decode", flush_decode, 1'b0);
        chk("br_flush_execute", flush_execute, 1'b1);
        tick();
        e_valid = 0; e_rf_we = 0;
        m_valid = 1; m_rf_we = 1; m_is_load = 0; m_rf_dest = 5'd7;
        e_rs1_addr = 5'd7; e_rs2_addr = 5'd9; w_rf_we = 1; w_rf_dest = 5'd9;
        #1;
        chk("br_fwd_rs2_d", fs2_d, 2'b10);
        chk("br_flush_decode2", flush_decode, 1'b1);
        chk("br_stall_decode2", stall_decode, 1'b0);
        chk("br_fwd_rs1_e", fs1_e, 2'b10);
        chk("br_fwd_rs2_e", fs2_e, 2'b01);
        tick();
        idle();
        #1;
        chk("br_stall_cnt", stall_cnt, 4'h2);
        chk("br_flush_cnt", flush_cnt, 4'h1);

        // Forwarding priority, all within one cycle
        decode_valid = 1; d_to_h_bus = {1'b0, 5'd3, 5'd0};
        m_valid = 1; m_rf_we = 1; m_rf_dest = 5'd3; m_is_load = 0;
        w_rf_we = 1; w_rf_dest = 5'd3; e_rs1_addr = 5'd3;
        #1;
        chk("fw_mem_alu", fs1_d, 2'b10);
        m_is_load = 1;
        #1;
        chk("fw_mem_load", fs1_d, 2'b00);
        chk("fw_mem_load_e", fs1_e, 2'b00);
        chk("fw_no_stall", stall_decode, 1'b0);
        m_is_load = 0; d_to_h_bus = {1'b0, 5'd0, 5'd0};
        #1;
        chk("fw_x0", fs1_d, 2'b00);
        d_to_h_bus = {1'b0, 5'd3, 5'd0}; m_valid = 0;
        #1;
        chk("fw_wb", fs1_d, 2'b01);
        idle();
        tick();
        chk("fw_stall_cnt", stall_cnt, 4'h2);

        // Memory wait of four cycles, taken branch suppressed throughout
        m_valid = 1; m_mem_access = 1; dmem_ready = 0; bj_taken = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("mw_stall_fetch", stall_fetch, 1'b1);
            chk("mw_stall_memory", stall_memory, 1'b1);
            chk("mw_stall_execute", stall_execute, 1'b1);
            chk("mw_flush_decode", flush_decode, 1'b0);
            chk("mw_flush_execute", flush_execute, 1'b0);
            tick();
        end
        dmem_ready = 1; bj_taken = 0;
        #1;
        chk("mw_ready_stall", stall_memory, 1'b0);
        tick();
        idle();
        tick();
        chk("mw_timeout_a", mem_timeout, 1'b0);
        chk("mw_stall_cnt", stall_cnt, 4'h6);
        chk("mw_flush_cnt", flush_cnt, 4'h1);

        // Reset in the middle of a memory wait
        pulse_reset();
        chk("rr_timeout_b", b_mem_timeout, 1'b0);
        m_valid = 1; m_mem_access = 1; dmem_ready = 0;
        tick();
        tick();
        pulse_reset();
        chk("rr_stall_cnt", stall_cnt, 4'h0);
        chk("rr_flush_cnt", flush_cnt, 4'h0);
        tick();
        tick();
        tick();
        chk("to_not_yet", b_mem_timeout, 1'b0);
        chk("to_stall_cnt", stall_cnt, 4'h3);
        tick();
        chk("to_set", b_mem_timeout, 1'b1);
        chk("to_a_clear", mem_timeout, 1'b0);
        dmem_ready = 1;
        tick();
        idle();
        tick();
        chk("to_sticky", b_mem_timeout, 1'b1);
        pulse_reset();
        chk("to_reset_clear", b_mem_timeout, 1'b0);

        // Counter saturation and clear priority
        tick();
        bj_taken = 1;
        tick();
        tick();
        bj_taken = 0;
        set_load_use();
        repeat (15) tick();
        chk("sat_reach", stall_cnt, 4'hF);
        tick();
        chk("sat_hold", stall_cnt, 4'hF);
        chk("sat_flush_cnt", flush_cnt, 4'h2);
        perf_clr = 1;
        tick();
        chk("clr_stall_cnt", stall_cnt, 4'h0);
        chk("clr_flush_cnt", flush_cnt, 4'h0);
        idle();
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
